// File: rtl/pixel_dispatcher_if.sv
// Calculator task handshake plus the result pixel stream of pixel_dispatcher.
// master = dispatcher side; slave = calculator / frame-buffer side.
interface pixel_dispatcher_if #(
  parameter int WIDTH  = 22,
  parameter int ADDR_W = 12
);
  logic              calc_start;
  logic [WIDTH-1:0]  z_real_out;
  logic [WIDTH-1:0]  z_imag_out;
  logic [WIDTH-1:0]  c_real_out;
  logic [WIDTH-1:0]  c_imag_out;
  logic [7:0]        iteration_out;
  logic              calc_done;
  logic [7:0]        pixel_in;
  logic              pix_valid;
  logic              pix_ready;
  logic [7:0]        pix_data;
  logic [ADDR_W-1:0] pix_addr;

  modport master (
    output calc_start, z_real_out, z_imag_out, c_real_out, c_imag_out, iteration_out,
    input  calc_done, pixel_in,
    output pix_valid, pix_data, pix_addr,
    input  pix_ready
  );

  modport slave (
    input  calc_start, z_real_out, z_imag_out, c_real_out, c_imag_out, iteration_out,
    output calc_done, pixel_in,
    input  pix_valid, pix_data, pix_addr,
    output pix_ready
  );
endinterface

// File: rtl/pixel_dispatcher.sv
// Raster-order Julia task issuer: feeds pixel_calculator and streams results out.
// Optional WAIT watchdog enabled by defining PIXEL_DISPATCHER_TIMEOUT_EN.
module pixel_dispatcher #(
  parameter int WIDTH      = 22,
  parameter int FRACTIONAL = 11,
  parameter int COLS       = 64,
  parameter int ROWS       = 48,
  parameter int ADDR_W     = $clog2(COLS*ROWS),
  parameter int TIMEOUT    = 260
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   c_real_in,
  input  logic [WIDTH-1:0]   c_imag_in,
  input  logic [WIDTH-1:0]   x_min_in,
  input  logic [WIDTH-1:0]   y_max_in,
  input  logic [WIDTH-1:0]   step_in,
  pixel_dispatcher_if.master bus,
  output logic               busy,
  output logic               frame_done,
  output logic               timeout_err
);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  if (FRACTIONAL < 0 || FRACTIONAL >= WIDTH || TIMEOUT < 1) begin : g_bad_params
    $error("pixel_dispatcher: FRACTIONAL must lie in [0, WIDTH) and TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUTPUT, DONE} state_e;

  state_e            state_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [WIDTH-1:0]  x_min_q, step_q, c_real_q, c_imag_q, z_real_q, z_imag_q;
  logic              calc_start_q, pix_valid_q, busy_q, frame_done_q;
  logic [7:0]        pix_data_q;
  logic [ADDR_W-1:0] pix_addr_q;
  logic              last_pixel;

  assign last_pixel = (col_q == LAST_COL) && (row_q == LAST_ROW);

`ifdef PIXEL_DISPATCHER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] wait_cnt_q;
  logic          timeout_err_q;
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      x_min_q      <= '0;
      step_q       <= '0;
      c_real_q     <= '0;
      c_imag_q     <= '0;
      z_real_q     <= '0;
      z_imag_q     <= '0;
      calc_start_q <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      pix_addr_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef PIXEL_DISPATCHER_TIMEOUT_EN
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start) begin
          x_min_q      <= x_min_in;
          step_q       <= step_in;
          c_real_q     <= c_real_in;
          c_imag_q     <= c_imag_in;
          z_real_q     <= x_min_in;
          z_imag_q     <= y_max_in;
          col_q        <= '0;
          row_q        <= '0;
          pix_addr_q   <= '0;
          calc_start_q <= 1'b1;
          busy_q       <= 1'b1;
          state_q      <= ISSUE;
`ifdef PIXEL_DISPATCHER_TIMEOUT_EN
          timeout_err_q <= 1'b0;
`endif
        end
        // The calculator still reports done from its idle state here; ignore it.
        ISSUE: begin
          state_q <= WAIT;
`ifdef PIXEL_DISPATCHER_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        WAIT: begin
          if (bus.calc_done) begin
            pix_data_q   <= bus.pixel_in;
            pix_valid_q  <= 1'b1;
            calc_start_q <= 1'b0;
            state_q      <= OUTPUT;
          end
`ifdef PIXEL_DISPATCHER_TIMEOUT_EN
          else if (wait_cnt_q == TIMEOUT_LAST) begin
            pix_data_q    <= 8'hFF;
            timeout_err_q <= 1'b1;
            pix_valid_q   <= 1'b1;
            calc_start_q  <= 1'b0;
            state_q       <= OUTPUT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        OUTPUT: if (bus.pix_ready) begin
          pix_valid_q <= 1'b0;
          pix_addr_q  <= pix_addr_q + 1'b1;
          if (last_pixel) begin
            frame_done_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            calc_start_q <= 1'b1;
            state_q      <= ISSUE;
            if (col_q == LAST_COL) begin
              col_q    <= '0;
              row_q    <= row_q + 1'b1;
              z_real_q <= x_min_q;
              z_imag_q <= z_imag_q - step_q;
            end else begin
              col_q    <= col_q + 1'b1;
              z_real_q <= z_real_q + step_q;
            end
          end
        end
        DONE: begin
          frame_done_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.calc_start    = calc_start_q;
  assign bus.z_real_out    = z_real_q;
  assign bus.z_imag_out    = z_imag_q;
  // busy_q mirrors "not IDLE", so c is only exposed while a frame runs.
  assign bus.c_real_out    = busy_q ? c_real_q : '0;
  assign bus.c_imag_out    = busy_q ? c_imag_q : '0;
  assign bus.iteration_out = 8'd0;
  assign bus.pix_valid     = pix_valid_q;
  assign bus.pix_data      = pix_data_q;
  assign bus.pix_addr      = pix_addr_q;
  assign busy              = busy_q;
  assign frame_done        = frame_done_q;
endmodule

// File: tb/tb_pixel_dispatcher.sv
// Scoreboard bench for pixel_dispatcher on a 4x2 grid with a behavioural calculator.
module tb_pixel_dispatcher;
  localparam int W    = 22;
  localparam int FR   = 11;
  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int NPIX = COLS * ROWS;
  localparam int AW   = $clog2(NPIX);
  localparam int TO   = 10;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic [W-1:0]  zr;
    logic [W-1:0]  zi;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] zr;
    logic [W-1:0] zi;
    logic [W-1:0] cr;
    logic [W-1:0] ci;
  } op_t;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] c_real_in = '0, c_imag_in = '0, x_min_in = '0, y_max_in = '0, step_in = '0;
  logic         busy, frame_done, timeout_err;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  op_t  op_q[$];
  int   model_mode = 0;   // 0: done after 2 WAIT cycles, 1: never done
  int   model_tasks = 0;
  int   model_cnt = 0;

  pixel_dispatcher_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

  pixel_dispatcher #(
    .WIDTH(W), .FRACTIONAL(FR), .COLS(COLS), .ROWS(ROWS), .ADDR_W(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start),
    .c_real_in(c_real_in), .c_imag_in(c_imag_in),
    .x_min_in(x_min_in), .y_max_in(y_max_in), .step_in(step_in),
    .bus(bus),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Calculator model: reports done while idle and during the load cycle,
  // then real done with a fresh result on the 2nd WAIT cycle.
  initial begin : calc_model
    op_t o;
    bus.calc_done = 1'b1;
    bus.pixel_in  = 8'hEE;
    forever begin
      @(negedge clk);
      if (bus.calc_start !== 1'b1) begin
        model_cnt = 0;
        bus.calc_done = 1'b1;
        bus.pixel_in  = 8'hEE;
      end else begin
        model_cnt++;
        if (model_cnt == 1) begin
          o.zr = bus.z_real_out; o.zi = bus.z_imag_out;
          o.cr = bus.c_real_out; o.ci = bus.c_imag_out;
          op_q.push_back(o);
          bus.calc_done = 1'b1;
          bus.pixel_in  = 8'hEE;
        end else if (model_cnt == 3 && model_mode == 0) begin
          bus.calc_done = 1'b1;
          bus.pixel_in  = 8'(42 + 17 * model_tasks);
          model_tasks++;
        end else begin
          bus.calc_done = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    n_rst = 1'b0; start = 1'b0; bus.pix_ready = 1'b0; model_mode = 0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_sb();
    exp_q.delete(); op_q.delete(); model_tasks = 0;
  endtask

  task automatic set_params(input int xm, input int ym, input int st, input int cr, input int ci);
    x_min_in = W'(xm); y_max_in = W'(ym); step_in = W'(st);
    c_real_in = W'(cr); c_imag_in = W'(ci);
  endtask

  task automatic push_frame(input int xm, input int ym, input int st);
    exp_t e;
    for (int i = 0; i < NPIX; i++) begin
      e.addr = AW'(i);
      e.data = 8'(42 + 17 * i);
      e.zr   = W'(xm + (i % COLS) * st);
      e.zi   = W'(ym - (i / COLS) * st);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start = 1'b1; bus.pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (bus.calc_start !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL reset_status got cs=%b busy=%b fd=%b te=%b exp 0000", bus.calc_start, busy, frame_done, timeout_err);
    end
    total++;
    if (bus.pix_valid !== 1'b0 || bus.pix_data !== 8'h00 || bus.pix_addr !== '0) begin
      bad++; $display("FAIL reset_stream got v=%b d=%h a=%0d exp 0/00/0", bus.pix_valid, bus.pix_data, bus.pix_addr);
    end
    total++;
    if (bus.z_real_out !== '0 || bus.z_imag_out !== '0 || bus.c_real_out !== '0 || bus.c_imag_out !== '0 || bus.iteration_out !== 8'h00) begin
      bad++; $display("FAIL reset_operands got zr=%h zi=%h cr=%h ci=%h it=%h exp all 0", bus.z_real_out, bus.z_imag_out, bus.c_real_out, bus.c_imag_out, bus.iteration_out);
    end
    start = 1'b0; n_rst = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || bus.calc_start !== 1'b0) begin
      bad++; $display("FAIL reset_release got busy=%b cs=%b exp 0/0", busy, bus.calc_start);
    end
  endtask

  task automatic test_frame_sweep();
    exp_t e; op_t o;
    int seen = 0, pulses = 0, cyc = 0, last_hs = -10, pulse_cyc = -1;
    bit after_hs = 1'b0;
    do_reset(); clear_sb();
    set_params(-2048, 1024, 1024, 300, -500);
    push_frame(-2048, 1024, 1024);
    bus.pix_ready = 1'b1;
    pulse_start();
    total++;
    if (bus.calc_start !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL sweep_start_latency got cs=%b busy=%b exp 1/1", bus.calc_start, busy);
    end
    set_params(777, -777, 3, 11, 12);  // a running frame must keep its latched values
    while (busy === 1'b1 && cyc < 300) begin
      if (after_hs) begin
        total++;
        if (bus.calc_start !== 1'b1 || bus.pix_valid !== 1'b0) begin
          bad++; $display("FAIL sweep_reissue got cs=%b v=%b exp 1/0", bus.calc_start, bus.pix_valid);
        end
        after_hs = 1'b0;
      end
      if (frame_done === 1'b1) begin pulses++; pulse_cyc = cyc; end
      if (bus.pix_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0 || op_q.size() == 0) begin
          bad++; $display("FAIL sweep_extra_pixel got addr=%0d exp no pixel", bus.pix_addr);
        end else begin
          e = exp_q.pop_front(); o = op_q.pop_front();
          if (bus.pix_addr !== e.addr || bus.pix_data !== e.data || bus.calc_start !== 1'b0) begin
            bad++; $display("FAIL sweep_pixel got a=%0d d=%h cs=%b exp a=%0d d=%h cs=0", bus.pix_addr, bus.pix_data, bus.calc_start, e.addr, e.data);
          end
          total++;
          if (o.zr !== e.zr || o.zi !== e.zi) begin
            bad++; $display("FAIL sweep_z addr=%0d got zr=%h zi=%h exp zr=%h zi=%h", e.addr, o.zr, o.zi, e.zr, e.zi);
          end
          total++;
          if (o.cr !== W'(300) || o.ci !== W'(-500)) begin
            bad++; $display("FAIL sweep_c got cr=%h ci=%h exp %h %h", o.cr, o.ci, W'(300), W'(-500));
          end
        end
        seen++; last_hs = cyc; after_hs = (seen < NPIX);
      end
      @(negedge clk); cyc++;
    end
    total++;
    if (seen != NPIX || exp_q.size() != 0) begin
      bad++; $display("FAIL sweep_count got %0d pixels exp %0d", seen, NPIX);
    end
    total++;
    if (pulses != 1 || pulse_cyc != last_hs + 1) begin
      bad++; $display("FAIL sweep_frame_done got pulses=%0d at=%0d exp 1 at=%0d", pulses, pulse_cyc, last_hs + 1);
    end
    total++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || cyc != last_hs + 2) begin
      bad++; $display("FAIL sweep_busy_drop got busy=%b fd=%b cyc=%0d exp 0/0 cyc=%0d", busy, frame_done, cyc, last_hs + 2);
    end
    total++;
    if (bus.c_real_out !== '0 || bus.c_imag_out !== '0) begin
      bad++; $display("FAIL sweep_idle_c got cr=%h ci=%h exp 0/0", bus.c_real_out, bus.c_imag_out);
    end
  endtask

  task automatic test_backpressure();
    int cyc = 0;
    do_reset(); clear_sb();
    set_params(0, 0, 5, 1, 2);
    bus.pix_ready = 1'b0;
    pulse_start();
    while (bus.pix_valid !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    total++;
    if (bus.pix_valid !== 1'b1 || bus.pix_data !== 8'h2A || bus.pix_addr !== '0) begin
      bad++; $display("FAIL bp_first got v=%b d=%h a=%0d exp 1/2a/0", bus.pix_valid, bus.pix_data, bus.pix_addr);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (bus.pix_valid !== 1'b1 || bus.pix_data !== 8'h2A || bus.pix_addr !== '0 || bus.calc_start !== 1'b0) begin
        bad++; $display("FAIL bp_hold cycle=%0d got v=%b d=%h a=%0d cs=%b exp 1/2a/0/0", k, bus.pix_valid, bus.pix_data, bus.pix_addr, bus.calc_start);
      end
    end
    bus.pix_ready = 1'b1;
    @(negedge clk);
    bus.pix_ready = 1'b0;
    total++;
    if (bus.pix_valid !== 1'b0 || bus.calc_start !== 1'b1 || bus.pix_addr !== AW'(1) || bus.z_real_out !== W'(5) || bus.z_imag_out !== '0) begin
      bad++; $display("FAIL bp_advance got v=%b cs=%b a=%0d zr=%h zi=%h exp 0/1/1/%h/0", bus.pix_valid, bus.calc_start, bus.pix_addr, bus.z_real_out, bus.z_imag_out, W'(5));
    end
    cyc = 0;
    while (bus.pix_valid !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    repeat (3) @(negedge clk);
    total++;
    if (bus.pix_valid !== 1'b1 || bus.pix_addr !== AW'(1) || bus.pix_data !== 8'h3B) begin
      bad++; $display("FAIL bp_one_step got v=%b a=%0d d=%h exp 1/1/3b", bus.pix_valid, bus.pix_addr, bus.pix_data);
    end
  endtask

  task automatic test_start_ignored_reset();
    exp_t e; op_t o;
    int hs = 0, cyc = 0;
    do_reset(); clear_sb();
    set_params(-2048, 1024, 1024, 7, 9);
    push_frame(-2048, 1024, 1024);
    bus.pix_ready = 1'b1;
    pulse_start();
    set_params(100, 200, 3, 55, 66);
    while (hs < 3 && cyc < 200) begin
      start = (cyc == 5);
      if (bus.pix_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0 || op_q.size() == 0) begin
          bad++; $display("FAIL midstart_extra got addr=%0d exp no pixel", bus.pix_addr);
          hs = 3;
        end else begin
          e = exp_q.pop_front(); o = op_q.pop_front();
          if (bus.pix_addr !== e.addr || bus.pix_data !== e.data || o.zr !== e.zr || o.zi !== e.zi || o.cr !== W'(7)) begin
            bad++; $display("FAIL midstart_pixel got a=%0d d=%h zr=%h zi=%h cr=%h exp a=%0d d=%h zr=%h zi=%h cr=7", bus.pix_addr, bus.pix_data, o.zr, o.zi, o.cr, e.addr, e.data, e.zr, e.zi);
          end
          hs++;
        end
      end
      @(negedge clk); cyc++;
    end
    start = 1'b0;
    bus.pix_ready = 1'b0;
    cyc = 0;
    while (bus.pix_valid !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    total++;
    if (bus.pix_valid !== 1'b1 || bus.pix_addr !== AW'(3)) begin
      bad++; $display("FAIL midstart_pixel3 got v=%b a=%0d exp 1/3", bus.pix_valid, bus.pix_addr);
    end
    n_rst = 1'b0;
    #1;
    total++;
    if (bus.calc_start !== 1'b0 || bus.pix_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || bus.pix_data !== 8'h00 || bus.pix_addr !== '0) begin
      bad++; $display("FAIL abort_status got cs=%b v=%b busy=%b fd=%b d=%h a=%0d exp all 0", bus.calc_start, bus.pix_valid, busy, frame_done, bus.pix_data, bus.pix_addr);
    end
    total++;
    if (bus.z_real_out !== '0 || bus.z_imag_out !== '0 || bus.c_real_out !== '0 || bus.c_imag_out !== '0) begin
      bad++; $display("FAIL abort_operands got zr=%h zi=%h cr=%h ci=%h exp all 0", bus.z_real_out, bus.z_imag_out, bus.c_real_out, bus.c_imag_out);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; n_rst = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || frame_done !== 1'b0) begin
      bad++; $display("FAIL abort_no_restart got busy=%b fd=%b exp 0/0", busy, frame_done);
    end
    clear_sb();
    set_params(1000, -1000, 10, 1, 2);
    push_frame(1000, -1000, 10);
    bus.pix_ready = 1'b1;
    pulse_start();
    cyc = 0;
    while (bus.pix_valid !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    total++;
    if (bus.pix_valid !== 1'b1 || exp_q.size() == 0 || op_q.size() == 0) begin
      bad++; $display("FAIL restart_valid got v=%b exp 1", bus.pix_valid);
    end else begin
      e = exp_q.pop_front(); o = op_q.pop_front();
      if (bus.pix_addr !== '0 || bus.pix_data !== 8'h2A || o.zr !== e.zr || o.zi !== e.zi) begin
        bad++; $display("FAIL restart_pixel got a=%0d d=%h zr=%h zi=%h exp 0/2a/%h/%h", bus.pix_addr, bus.pix_data, o.zr, o.zi, e.zr, e.zi);
      end
    end
  endtask

`ifdef PIXEL_DISPATCHER_TIMEOUT_EN
  task automatic test_timeout();
    int cyc = 0;
    bit held = 1'b1;
    do_reset(); clear_sb();
    model_mode = 1;
    set_params(0, 0, 1, 0, 0);
    bus.pix_ready = 1'b0;
    pulse_start();
    repeat (TO) @(negedge clk);
    total++;
    if (bus.pix_valid !== 1'b0 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL timeout_early got v=%b te=%b exp 0/0", bus.pix_valid, timeout_err);
    end
    @(negedge clk);
    total++;
    if (bus.pix_valid !== 1'b1 || bus.pix_data !== 8'hFF || timeout_err !== 1'b1) begin
      bad++; $display("FAIL timeout_fire got v=%b d=%h te=%b exp 1/ff/1", bus.pix_valid, bus.pix_data, timeout_err);
    end
    model_mode = 0; model_tasks = 1;
    bus.pix_ready = 1'b1;
    while (busy === 1'b1 && cyc < 300) begin
      if (timeout_err !== 1'b1) held = 1'b0;
      @(negedge clk); cyc++;
    end
    total++;
    if (!held || busy !== 1'b0 || timeout_err !== 1'b1) begin
      bad++; $display("FAIL timeout_sticky got held=%b busy=%b te=%b exp 1/0/1", held, busy, timeout_err);
    end
    pulse_start();
    total++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL timeout_clear got te=%b busy=%b exp 0/1", timeout_err, busy);
    end
  endtask
`endif

  initial begin
    bus.pix_ready = 1'b0;
    test_reset();
    test_frame_sweep();
    test_backpressure();
    test_start_ignored_reset();
`ifdef PIXEL_DISPATCHER_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
